// File: rtl/reset_sequencer_pkg.sv
// Shared encodings for the reset sequencer: FSM states, cause bit positions,
// and a width helper for parameter-sized counters.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   localparam int CAUSE_EXT = 0;
   localparam int CAUSE_SW  = 1;
   localparam int CAUSE_WDT = 2;

   // Bits needed to hold values 0..max_val inclusive (at least one bit).
   function automatic int cnt_bits(input int max_val);
      if (max_val < 2) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Board button front end: 2-FF synchroniser followed by a saturating
// low-time counter; ext_req_o stays high while the button is held.
module reset_sequencer_debounce
   import reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ext_n_i,
   output logic ext_req_o
);

   localparam int DW = cnt_bits(DEBOUNCE);

   logic [1:0]    sync_q, sync_d;
   logic [DW-1:0] deb_q, deb_d;

   // Any high synchronised sample restarts the low-time count.
   always_comb begin
      sync_d = {sync_q[0], ext_n_i};
      deb_d  = deb_q;
      if (sync_q[1]) begin
         deb_d = '0;
      end else if (deb_q != DW'(DEBOUNCE)) begin
         deb_d = deb_q + DW'(1);
      end else begin
         deb_d = deb_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         deb_q  <= '0;
      end else begin
         sync_q <= sync_d;
         deb_q  <= deb_d;
      end
   end

   assign ext_req_o = (deb_q == DW'(DEBOUNCE));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds every channel low after any reset source,
// then releases channel 0 first and the rest one gap apart.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NCH         = 3,
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 256,
   parameter int STAGE_GAP   = 16,
   parameter int DEBOUNCE    = 4,
   parameter int WDT_CYCLES  = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ext_rst_req_n,
   input  logic           sw_rst_req,
   input  logic           wdt_kick,
   output logic [NCH-1:0] rst_out_n,
   output logic           busy,
   output logic [2:0]     rst_cause
);

   localparam int STG_W = cnt_bits(NCH);

   if ((NCH < 1) || (NCH > 8) || (CNT_W < 1) || (CNT_W > 31) ||
       (HOLD_CYCLES < 1) || (64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) ||
       (STAGE_GAP < 1) || (64'(STAGE_GAP) >= (64'd1 << CNT_W)) ||
       (DEBOUNCE < 1) || (WDT_CYCLES < 0)) begin : g_param_check
      $error("reset_sequencer: parameter out of range");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic [NCH-1:0]   rst_out_q, rst_out_d;
   logic             busy_q, busy_d;
   logic [2:0]       cause_q, cause_d;
   logic             ext_req_s, wdt_req_s, any_req_s;
   logic [2:0]       req_vec_s;

   reset_sequencer_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .ext_n_i   (ext_rst_req_n),
      .ext_req_o (ext_req_s)
   );

   assign req_vec_s[CAUSE_EXT] = ext_req_s;
   assign req_vec_s[CAUSE_SW]  = sw_rst_req;
   assign req_vec_s[CAUSE_WDT] = wdt_req_s;
   assign any_req_s            = |req_vec_s;

   if (WDT_CYCLES > 0) begin : g_wdt
      localparam int WW = cnt_bits(WDT_CYCLES);
      logic [WW-1:0] wdt_q, wdt_d;

      always_comb begin
         wdt_d = wdt_q;
         if ((state_q != ST_RUN) || wdt_kick || any_req_s) begin
            wdt_d = '0;
         end else begin
            wdt_d = wdt_q + WW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            wdt_q <= '0;
         end else begin
            wdt_q <= wdt_d;
         end
      end

      // A kick in the expiry cycle suppresses the request.
      assign wdt_req_s = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WW'(WDT_CYCLES - 1));
   end else begin : g_no_wdt
      logic wdt_unused_s;
      assign wdt_unused_s = wdt_kick;
      assign wdt_req_s    = 1'b0;
   end

   // stage counts released channels; outputs are a thermometer of it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stage_d   = stage_q;
      cause_d   = cause_q;
      rst_out_d = '0;
      if (any_req_s) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         stage_d = '0;
         cause_d = req_vec_s;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  cnt_d   = '0;
                  stage_d = STG_W'(1);
                  state_d = (NCH == 1) ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                  cnt_d   = '0;
                  stage_d = stage_q + STG_W'(1);
                  state_d = (stage_q == STG_W'(NCH - 1)) ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               cnt_d   = '0;
               stage_d = STG_W'(NCH);
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               stage_d = '0;
            end
         endcase
      end
      for (int i = 0; i < NCH; i++) begin
         rst_out_d[i] = (stage_d > STG_W'(i));
      end
      busy_d = ~&rst_out_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_HOLD;
         cnt_q     <= '0;
         stage_q   <= '0;
         rst_out_q <= '0;
         busy_q    <= 1'b1;
         cause_q   <= 3'b000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
         cause_q   <= cause_d;
      end
   end

   assign rst_out_n = rst_out_q;
   assign busy      = busy_q;
   assign rst_cause = cause_q;

endmodule
